liteeth_sram_fifo_ctrl: RTL and testbench
=========================================

Name: liteeth_sram_fifo_ctrl

Overview:
- Stream FIFO controller that uses the 1rw1r 64x64 SRAM macro as its storage.
- Writes go through the rw port and reads through the r port.
- A 2-entry output skid buffer hides the 1-cycle SRAM read latency, giving first-word-fall-through at 1 word/cycle sustained.
- Sits between the liteeth MAC stream and the packet buffer; the SRAM macro is instantiated next to this block.

Parameters:
BITS, 64, data width; must match the SRAM macro
WORD_DEPTH, 64, SRAM depth; power of two
ADDR_WIDTH, 6, log2(WORD_DEPTH)

Ports:
clk  input  1  single clock for the block and both SRAM ports
rst_n  input  1  reset, asynchronous and active-low
flush  input  1  synchronous clear of all FIFO state
s_valid  input  1  write request
s_ready  output  1  write accept
s_data  input  BITS  write data
m_valid  output  1  head word valid
m_ready  input  1  head word consumed
m_data  output  BITS  head word
level  output  ADDR_WIDTH+2  words held (SRAM + in-flight + skid)
rw0_ce  output  1  SRAM rw port chip enable
rw0_we  output  1  SRAM rw port write enable
rw0_addr  output  ADDR_WIDTH  SRAM rw port address
rw0_wd  output  BITS  SRAM rw port write data
r0_ce  output  1  SRAM read port chip enable
r0_addr  output  ADDR_WIDTH  SRAM read port address
r0_rd  input  BITS  SRAM read data; valid the cycle after r0_ce is sampled

Behaviour:
- State:
  - wp, rp: ADDR_WIDTH+1-bit pointers, wrapping modulo 2*WORD_DEPTH.
  - mem_cnt = wp - rp (modulo arithmetic).
  - inflight: 1 bit.
  - skid: 2 entries plus out_cnt (0..2).
- Reset (async, rst_n=0): wp=rp=0, inflight=0, out_cnt=0. All outputs are then deasserted:
  - s_ready=0 while rst_n=0.
  - m_valid=0, level=0.
  - rw0_ce=rw0_we=r0_ce=0, addresses=0.
- Outputs are never X after reset.
- Write:
  - s_ready = (mem_cnt < WORD_DEPTH) && !flush.
  - On s_valid&&s_ready: rw0_ce=rw0_we=1, rw0_addr=wp[ADDR_WIDTH-1:0], rw0_wd=s_data, then wp++.
  - Otherwise rw0_ce=rw0_we=0.
- Read issue: r0_ce=1, r0_addr=rp[ADDR_WIDTH-1:0], then rp++, when all of these hold:
  - mem_cnt != 0
  - (out_cnt + inflight - pop) < 2, where pop = m_valid && m_ready
  - !flush
- inflight is set on the cycle after a read is issued. In that cycle r0_rd is pushed into the skid behind any older entry.
- r0_rd is sampled only when inflight=1, because it is X when r0_ce was low.
- Read/write hazard: rp != wp is registered before the read issues, so the read address never equals the address being written in the same cycle. No read-during-write collision on the same word can occur.
- Head: m_valid = (out_cnt != 0). m_data = skid[0], held stable while m_valid && !m_ready.
- Simultaneous pop and push: the skid shifts and the new word lands in the freed slot; out_cnt is unchanged.
- Latency: an s handshake in cycle N into an empty FIFO gives r0_ce in N+1 and m_valid in N+3.
- Throughput: with m_ready held high, one word per cycle in steady state with no bubbles.
- level = mem_cnt + inflight + out_cnt. Range 0..WORD_DEPTH+2, registered-state derived.
- Full: s_ready drops exactly when mem_cnt == WORD_DEPTH, even if the skid has drained free space. Entries moved into the skid free SRAM space immediately.
- Flush (sync, takes priority over every handshake in the same cycle):
  - Next cycle: wp=rp=0, out_cnt=0, inflight=0.
  - Returning data from a read in flight is discarded.
  - s_ready=0 and r0_ce=0 during the flush cycle.
- Reset mid-operation: all state clears immediately and no SRAM write is issued.
- SRAM contents are not cleared by reset or flush; stale words are unreachable because the pointers reset.

Test Plan:
- Reset, then write 0x0000_0000_0000_0001 with m_ready=1 -> r0_ce one cycle after the write, m_valid 3 cycles after the write, m_data=0x...01, level returns to 0.
- m_ready=0, write 66 words 0..65 -> all accepted (64 in SRAM, 2 in skid), s_ready=0 at level=66. Raise m_ready -> 0..65 out in order, one per cycle, no gaps.
- Stream 200 words with s_valid and m_ready both high -> output sequence equals input, pointers wrap past 127, no bubble after the initial 3-cycle fill.
- Random m_ready (50%) on 500 words -> m_data stable while stalled, no loss or duplication, level always equals pushed minus popped.
- Assert flush in the cycle a read returns with level=10 -> next cycle m_valid=0 and level=0. A subsequent write of 0xAA is the first word out.
- Pulse rst_n low mid-stream -> m_valid, level, rw0_ce and r0_ce go to 0 asynchronously. After release, a new word 0x55 is output correctly.

Source files
------------

// File: rtl/liteeth_sram_fifo_ctrl.sv
// Stream FIFO controller on a 1rw1r SRAM macro.
// A 2-entry skid buffer hides the SRAM read latency (FWFT).
module liteeth_sram_fifo_ctrl #(
    parameter int BITS       = 64,
    parameter int WORD_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BITS-1:0]       s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [BITS-1:0]       m_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  rw0_ce,
    output logic                  rw0_we,
    output logic [ADDR_WIDTH-1:0] rw0_addr,
    output logic [BITS-1:0]       rw0_wd,
    output logic                  r0_ce,
    output logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [BITS-1:0]       r0_rd
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int LW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(WORD_DEPTH);

    logic [PW-1:0]   wp_q, wp_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic [PW-1:0]   mem_cnt;
    logic            inflight_q, inflight_d;
    logic [1:0]      out_cnt_q, out_cnt_d;
    logic [BITS-1:0] skid0_q, skid0_d;
    logic [BITS-1:0] skid1_q, skid1_d;
    logic            wr_en;
    logic            rd_en;
    logic            pop;
    logic            push;
    logic [2:0]      occ_after_pop;
    logic [1:0]      base;

    // Handshakes and read-issue decision from registered state.
    always_comb begin
        mem_cnt       = wp_q - rp_q;
        s_ready       = rst_n && (mem_cnt < DEPTH_P) && !flush;
        wr_en         = s_valid && s_ready;
        m_valid       = (out_cnt_q != 2'd0);
        pop           = m_valid && m_ready;
        occ_after_pop = {1'b0, out_cnt_q} + {2'b0, inflight_q}
                      - {2'b0, pop};
        rd_en         = (mem_cnt != '0) && (occ_after_pop < 3'd2)
                      && !flush;
        push          = inflight_q && !flush;
    end

    // SRAM port drive, head word and occupancy.
    always_comb begin
        rw0_ce   = wr_en;
        rw0_we   = wr_en;
        rw0_addr = wp_q[ADDR_WIDTH-1:0];
        rw0_wd   = wr_en ? s_data : '0;
        r0_ce    = rd_en;
        r0_addr  = rp_q[ADDR_WIDTH-1:0];
        m_data   = skid0_q;
        level    = LW'(mem_cnt) + LW'(inflight_q) + LW'(out_cnt_q);
    end

    // Pointer and in-flight next state; flush wins over everything.
    always_comb begin
        wp_d       = wp_q + PW'(wr_en);
        rp_d       = rp_q + PW'(rd_en);
        inflight_d = rd_en;
        if (flush) begin
            wp_d       = '0;
            rp_d       = '0;
            inflight_d = 1'b0;
        end
    end

    // Skid buffer: shift on pop, returning word fills first free slot.
    always_comb begin
        skid0_d = skid0_q;
        skid1_d = skid1_q;
        base    = out_cnt_q;
        if (pop) begin
            skid0_d = skid1_q;
            base    = out_cnt_q - 2'd1;
        end
        if (push) begin
            if (base == 2'd0) begin
                skid0_d = r0_rd;
            end else begin
                skid1_d = r0_rd;
            end
        end
        out_cnt_d = base + {1'b0, push};
        if (flush) begin
            out_cnt_d = 2'd0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            inflight_q <= 1'b0;
            out_cnt_q  <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            inflight_q <= inflight_d;
            out_cnt_q  <= out_cnt_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
        end
    end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Self-checking bench for liteeth_sram_fifo_ctrl.
// Includes a behavioural 1rw1r SRAM model.
module tb_liteeth_sram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [7:0]  level;
    logic        rw0_ce;
    logic        rw0_we;
    logic [5:0]  rw0_addr;
    logic [63:0] rw0_wd;
    logic        r0_ce;
    logic [5:0]  r0_addr;
    logic [63:0] r0_rd;

    int checks = 0;
    int failures = 0;

    liteeth_sram_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level),
        .rw0_ce(rw0_ce), .rw0_we(rw0_we), .rw0_addr(rw0_addr),
        .rw0_wd(rw0_wd),
        .r0_ce(r0_ce), .r0_addr(r0_addr), .r0_rd(r0_rd)
    );

    always #5 clk = ~clk;

    logic [63:0] sram [64];
    initial r0_rd = '0;
    always @(posedge clk) begin
        if (rw0_ce && rw0_we) sram[rw0_addr] <= rw0_wd;
        if (r0_ce) r0_rd <= sram[r0_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        sv;
        logic [63:0] sd;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic [63:0] e_md;
        logic [7:0]  e_lvl;
        logic        e_rce;
        logic        e_wce;
    } vec_t;

    vec_t vt [12];

    task automatic run_stream(input int total, input bit rnd);
        logic [63:0] q [$];
        int pushed = 0;
        int popped = 0;
        int bubbles = 0;
        int t = 0;
        bit seen = 0;
        bit stall = 0;
        bit ih, oh;
        logic [63:0] prev = '0;
        while (popped < total && t < 5000) begin
            s_valid = (pushed < total);
            s_data  = 64'hC0DE_0000_0000_0000 | 64'(pushed);
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("strm_level", 64'(level), 64'(pushed - popped));
            if (m_valid) begin
                if (q.size() == 0) begin
                    chk("strm_spurious", 64'(m_valid), 64'd0);
                end else begin
                    chk("strm_data", m_data, q[0]);
                end
            end
            if (stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", m_data, prev);
            end
            if (seen && !m_valid && popped < total) bubbles++;
            seen  = seen || m_valid;
            ih    = s_valid && s_ready;
            oh    = m_valid && m_ready;
            stall = m_valid && !m_ready;
            prev  = m_data;
            @(posedge clk);
            if (ih) begin
                q.push_back(s_data);
                pushed++;
            end
            if (oh) begin
                void'(q.pop_front());
                popped++;
            end
            #1;
            t++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("strm_done", 64'(popped), 64'(total));
        if (!rnd) chk("strm_bubbles", 64'(bubbles), 64'd0);
    endtask

    initial begin
        int n;
        int t;
        int k;
        bit acc;

        vt[0]  = '{1, 64'h1, 1, 1, 0, 64'h0, 8'd0, 0, 1};
        vt[1]  = '{0, 64'h0, 1, 1, 0, 64'h0, 8'd1, 1, 0};
        vt[2]  = '{0, 64'h0, 1, 1, 0, 64'h0, 8'd1, 0, 0};
        vt[3]  = '{0, 64'h0, 1, 1, 1, 64'h1, 8'd1, 0, 0};
        vt[4]  = '{1, 64'h2, 0, 1, 0, 64'h0, 8'd0, 0, 1};
        vt[5]  = '{1, 64'h3, 0, 1, 0, 64'h0, 8'd1, 1, 1};
        vt[6]  = '{0, 64'h0, 0, 1, 0, 64'h0, 8'd2, 1, 0};
        vt[7]  = '{0, 64'h0, 0, 1, 1, 64'h2, 8'd2, 0, 0};
        vt[8]  = '{0, 64'h0, 0, 1, 1, 64'h2, 8'd2, 0, 0};
        vt[9]  = '{0, 64'h0, 1, 1, 1, 64'h2, 8'd2, 0, 0};
        vt[10] = '{0, 64'h0, 1, 1, 1, 64'h3, 8'd1, 0, 0};
        vt[11] = '{0, 64'h0, 0, 1, 0, 64'h0, 8'd0, 0, 0};

        rst_n = 1'b0;
        flush = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        s_valid = 1'b1;
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_rw0_ce", 64'(rw0_ce), 64'd0);
        chk("rst_r0_ce", 64'(r0_ce), 64'd0);
        chk("rst_addr", 64'({rw0_addr, r0_addr}), 64'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 12; i++) begin
            s_valid = vt[i].sv;
            s_data  = vt[i].sd;
            m_ready = vt[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d_s_ready", i), 64'(s_ready),
                64'(vt[i].e_sr));
            chk($sformatf("vec%0d_m_valid", i), 64'(m_valid),
                64'(vt[i].e_mv));
            if (vt[i].e_mv)
                chk($sformatf("vec%0d_m_data", i), m_data, vt[i].e_md);
            chk($sformatf("vec%0d_level", i), 64'(level),
                64'(vt[i].e_lvl));
            chk($sformatf("vec%0d_r0_ce", i), 64'(r0_ce),
                64'(vt[i].e_rce));
            chk($sformatf("vec%0d_rw0_ce", i), 64'(rw0_ce),
                64'(vt[i].e_wce));
            cyc();
        end

        // Fill: 64 words in SRAM plus 2 in skid.
        m_ready = 1'b0;
        s_valid = 1'b1;
        n = 0;
        t = 0;
        s_data = 64'(n);
        while (n < 66 && t < 300) begin
            @(negedge clk);
            acc = s_ready;
            cyc();
            if (acc) begin
                n++;
                s_data = 64'(n);
            end
            t++;
        end
        s_valid = 1'b0;
        chk("full_accepted", 64'(n), 64'd66);
        repeat (3) cyc();
        s_valid = 1'b1;
        s_data = 64'd99;
        @(negedge clk);
        chk("full_level", 64'(level), 64'd66);
        chk("full_s_ready", 64'(s_ready), 64'd0);
        chk("full_rw0_ce", 64'(rw0_ce), 64'd0);
        chk("full_head", m_data, 64'd0);
        cyc();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            chk("drain_valid", 64'(m_valid), 64'd1);
            chk("drain_data", m_data, 64'(i));
            cyc();
        end
        m_ready = 1'b0;
        @(negedge clk);
        chk("drain_level", 64'(level), 64'd0);
        cyc();

        run_stream(200, 1'b0);
        run_stream(500, 1'b1);

        // Flush while a read is returning, level 10.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data = 64'h100 + 64'(i);
            cyc();
        end
        s_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("pre_flush_level", 64'(level), 64'd10);
        cyc();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = 64'h10A;
        @(negedge clk);
        chk("pre_flush_head", m_data, 64'h100);
        cyc();
        m_ready = 1'b0;
        s_data = 64'hBB;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cyc_level", 64'(level), 64'd10);
        chk("flush_s_ready", 64'(s_ready), 64'd0);
        chk("flush_r0_ce", 64'(r0_ce), 64'd0);
        chk("flush_rw0_ce", 64'(rw0_ce), 64'd0);
        cyc();
        flush = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", 64'(m_valid), 64'd0);
        chk("post_flush_level", 64'(level), 64'd0);
        cyc();
        s_valid = 1'b1;
        s_data = 64'hAA;
        m_ready = 1'b1;
        cyc();
        s_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!m_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("aa_valid", 64'(m_valid), 64'd1);
        chk("aa_data", m_data, 64'hAA);
        cyc();
        @(negedge clk);
        chk("aa_level", 64'(level), 64'd0);
        cyc();

        // Asynchronous reset mid-stream.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = 64'h200 + 64'(i);
            cyc();
        end
        chk("pre_rst_valid", 64'(m_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 64'(m_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_rw0_ce", 64'(rw0_ce), 64'd0);
        chk("arst_r0_ce", 64'(r0_ce), 64'd0);
        chk("arst_s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        s_valid = 1'b1;
        s_data = 64'h55;
        m_ready = 1'b1;
        cyc();
        s_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!m_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("r55_valid", 64'(m_valid), 64'd1);
        chk("r55_data", m_data, 64'h55);
        cyc();
        @(negedge clk);
        chk("r55_level", 64'(level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
